// File: rtl/id_ex_pipe_reg.sv
// Decode->Execute pipeline register with stall/flush handling and a saturating
// count of bubbles inserted by flush.
module id_ex_pipe_reg #(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5,
  parameter int CNTW    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               StallE,
  input  logic               FlushE,
  input  logic               ValidD,
  input  logic [XLEN-1:0]    PCD,
  input  logic [XLEN-1:0]    PCPlus4D,
  input  logic [XLEN-1:0]    RD1D,
  input  logic [XLEN-1:0]    RD2D,
  input  logic [XLEN-1:0]    ImmExtD,
  input  logic [REGADDR-1:0] RegSource1D,
  input  logic [REGADDR-1:0] RegSource2D,
  input  logic [REGADDR-1:0] RegDestinD,
  input  logic               RegWriteD,
  input  logic [1:0]         ResultSrcD,
  input  logic               MemWriteD,
  input  logic               JumpD,
  input  logic               BranchD,
  input  logic [2:0]         ALUControlD,
  input  logic               ALUSrcD,
  output logic               ValidE,
  output logic [XLEN-1:0]    PCE,
  output logic [XLEN-1:0]    PCPlus4E,
  output logic [XLEN-1:0]    RD1E,
  output logic [XLEN-1:0]    RD2E,
  output logic [XLEN-1:0]    ImmExtE,
  output logic [REGADDR-1:0] RegSource1E,
  output logic [REGADDR-1:0] RegSource2E,
  output logic [REGADDR-1:0] RegDestinE,
  output logic               RegWriteE,
  output logic [1:0]         ResultSrcE,
  output logic               MemWriteE,
  output logic               JumpE,
  output logic               BranchE,
  output logic [2:0]         ALUControlE,
  output logic               ALUSrcE,
  output logic [CNTW-1:0]    BubbleCountE
);

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc_plus4;
    logic [XLEN-1:0]    rd1;
    logic [XLEN-1:0]    rd2;
    logic [XLEN-1:0]    imm;
    logic [REGADDR-1:0] rs1;
    logic [REGADDR-1:0] rs2;
    logic [REGADDR-1:0] rd;
    logic               reg_write;
    logic [1:0]         result_src;
    logic               mem_write;
    logic               jump;
    logic               branch;
    logic [2:0]         alu_control;
    logic               alu_src;
  } e_stage_t;

  e_stage_t        stage_d, stage_q;
  logic [CNTW-1:0] bubble_cnt_d, bubble_cnt_q;

  always_comb begin
    stage_d      = stage_q;
    bubble_cnt_d = bubble_cnt_q;
    if (FlushE) begin
      // An all-zero slot keeps forwarding pointed at x0 and suppresses side effects.
      stage_d = '0;
      if (bubble_cnt_q != {CNTW{1'b1}})
        bubble_cnt_d = bubble_cnt_q + CNTW'(1);
    end else if (!StallE) begin
      stage_d.valid       = ValidD;
      stage_d.pc          = PCD;
      stage_d.pc_plus4    = PCPlus4D;
      stage_d.rd1         = RD1D;
      stage_d.rd2         = RD2D;
      stage_d.imm         = ImmExtD;
      stage_d.rs1         = RegSource1D;
      stage_d.rs2         = RegSource2D;
      stage_d.rd          = RegDestinD;
      stage_d.reg_write   = RegWriteD;
      stage_d.result_src  = ResultSrcD;
      stage_d.mem_write   = MemWriteD;
      stage_d.jump        = JumpD;
      stage_d.branch      = BranchD;
      stage_d.alu_control = ALUControlD;
      stage_d.alu_src     = ALUSrcD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q      <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stage_q      <= stage_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ValidE       = stage_q.valid;
  assign PCE          = stage_q.pc;
  assign PCPlus4E     = stage_q.pc_plus4;
  assign RD1E         = stage_q.rd1;
  assign RD2E         = stage_q.rd2;
  assign ImmExtE      = stage_q.imm;
  assign RegSource1E  = stage_q.rs1;
  assign RegSource2E  = stage_q.rs2;
  assign RegDestinE   = stage_q.rd;
  assign RegWriteE    = stage_q.reg_write;
  assign ResultSrcE   = stage_q.result_src;
  assign MemWriteE    = stage_q.mem_write;
  assign JumpE        = stage_q.jump;
  assign BranchE      = stage_q.branch;
  assign ALUControlE  = stage_q.alu_control;
  assign ALUSrcE      = stage_q.alu_src;
  assign BubbleCountE = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed scoreboard bench for id_ex_pipe_reg, built with a 4-bit bubble counter.
module tb_id_ex_pipe_reg;
  localparam int XLEN = 32;
  localparam int RA   = 5;
  localparam int CNTW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic StallE, FlushE, ValidD;
  logic [XLEN-1:0] PCD, PCPlus4D, RD1D, RD2D, ImmExtD;
  logic [RA-1:0] RegSource1D, RegSource2D, RegDestinD;
  logic RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0] ResultSrcD;
  logic [2:0] ALUControlD;
  logic ValidE;
  logic [XLEN-1:0] PCE, PCPlus4E, RD1E, RD2E, ImmExtE;
  logic [RA-1:0] RegSource1E, RegSource2E, RegDestinE;
  logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0] ResultSrcE;
  logic [2:0] ALUControlE;
  logic [CNTW-1:0] BubbleCountE;

  id_ex_pipe_reg #(.XLEN(XLEN), .REGADDR(RA), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .RegSource1D(RegSource1D), .RegSource2D(RegSource2D), .RegDestinD(RegDestinD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .JumpD(JumpD), .BranchD(BranchD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
    .ValidE(ValidE), .PCE(PCE), .PCPlus4E(PCPlus4E), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .RegSource1E(RegSource1E), .RegSource2E(RegSource2E),
    .RegDestinE(RegDestinE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .BubbleCountE(BubbleCountE)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc, pc4, rd1, rd2, imm;
    logic [RA-1:0]   rs1, rs2, rd;
    logic            rw;
    logic [1:0]      rsrc;
    logic            mw, jmp, br;
    logic [2:0]      aluc;
    logic            alus;
    logic [CNTW-1:0] cnt;
  } exp_t;

  exp_t model;
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    chk({tag, ".ValidE"},   64'(ValidE),   64'(e.valid));
    chk({tag, ".PCE"},      64'(PCE),      64'(e.pc));
    chk({tag, ".PCPlus4E"}, 64'(PCPlus4E), 64'(e.pc4));
    chk({tag, ".RD1E"},     64'(RD1E),     64'(e.rd1));
    chk({tag, ".RD2E"},     64'(RD2E),     64'(e.rd2));
    chk({tag, ".ImmExtE"},  64'(ImmExtE),  64'(e.imm));
    chk({tag, ".regaddr"},  64'({RegSource1E, RegSource2E, RegDestinE}),
                            64'({e.rs1, e.rs2, e.rd}));
    chk({tag, ".ctrl"},     64'({RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE}),
                            64'({e.rw, e.rsrc, e.mw, e.jmp, e.br, e.aluc, e.alus}));
    chk({tag, ".BubbleCountE"}, 64'(BubbleCountE), 64'(e.cnt));
  endtask

  task automatic rand_d();
    ValidD = 1'($urandom); PCD = $urandom; PCPlus4D = $urandom; RD1D = $urandom;
    RD2D = $urandom; ImmExtD = $urandom; RegSource1D = RA'($urandom);
    RegSource2D = RA'($urandom); RegDestinD = RA'($urandom); RegWriteD = 1'($urandom);
    ResultSrcD = 2'($urandom); MemWriteD = 1'($urandom); JumpD = 1'($urandom);
    BranchD = 1'($urandom); ALUControlD = 3'($urandom); ALUSrcD = 1'($urandom);
  endtask

  task automatic zero_d();
    ValidD = 0; PCD = 0; PCPlus4D = 0; RD1D = 0; RD2D = 0; ImmExtD = 0;
    RegSource1D = 0; RegSource2D = 0; RegDestinD = 0; RegWriteD = 0; ResultSrcD = 0;
    MemWriteD = 0; JumpD = 0; BranchD = 0; ALUControlD = 0; ALUSrcD = 0;
  endtask

  // Drive one cycle, predict from the reference behaviour, compare after the edge.
  task automatic step(input string tag, input logic fl, input logic st);
    exp_t e;
    FlushE = fl;
    StallE = st;
    if (fl) begin
      model = '{cnt: (model.cnt == 4'hF) ? 4'hF : model.cnt + 4'd1, default: '0};
    end else if (!st) begin
      model.valid = ValidD; model.pc = PCD; model.pc4 = PCPlus4D; model.rd1 = RD1D;
      model.rd2 = RD2D; model.imm = ImmExtD; model.rs1 = RegSource1D;
      model.rs2 = RegSource2D; model.rd = RegDestinD; model.rw = RegWriteD;
      model.rsrc = ResultSrcD; model.mw = MemWriteD; model.jmp = JumpD;
      model.br = BranchD; model.aluc = ALUControlD; model.alus = ALUSrcD;
    end
    sb_q.push_back(model);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_outputs(tag, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model = '0;
    rst_n = 1'b0;
    StallE = 0; FlushE = 0;
    // Reset held with random inputs and edges
    for (int i = 0; i < 3; i++) begin
      rand_d();
      FlushE = 1'($urandom); StallE = 1'($urandom);
      @(posedge clk); #1;
      check_outputs("reset_hold", '0);
    end
    zero_d();
    FlushE = 0; StallE = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step("first_after_reset", 0, 0);

    // Pass-through
    ValidD = 1; PCD = 32'h100; RD1D = 32'hDEADBEEF; RegSource1D = 5;
    RegDestinD = 7; RegWriteD = 1;
    step("pass", 0, 0);

    // Stall holds
    PCD = 32'h200;
    step("stall_load", 0, 0);
    PCD = 32'h300;
    for (int i = 0; i < 3; i++) step("stall_hold", 0, 1);
    step("stall_release", 0, 0);

    // Flush over stall
    RegWriteD = 1; RegDestinD = 9; ValidD = 1;
    step("flush_over_stall", 1, 1);

    // Random loads, including ValidD=0 slots, then a stall with random inputs
    for (int i = 0; i < 6; i++) begin
      rand_d();
      step("rand_load", 0, 0);
    end
    rand_d(); ValidD = 0;
    step("invalid_load", 0, 0);
    rand_d();
    step("rand_stall", 0, 1);

    // Saturation
    for (int i = 0; i < 20; i++) begin
      rand_d();
      step("flush_sat", 1, 0);
    end
    chk("sat_final", 64'(BubbleCountE), 64'd15);
    rand_d();
    step("post_sat_stall", 0, 1);
    rand_d(); ValidD = 0;
    step("post_sat_invalid", 0, 0);
    rand_d();
    step("post_sat_load", 0, 0);

    // Async reset between edges during a stall
    rand_d();
    FlushE = 0; StallE = 1;
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_reset", '0);
    model = '0;
    @(posedge clk); #1;
    check_outputs("async_reset_edge", '0);
    @(negedge clk);
    rst_n = 1'b1;
    rand_d();
    step("after_async_reset", 0, 0);
    step("after_async_flush", 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
